// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one MAC transmit byte stream between two sources.
// Whole frames are granted, an idle gap follows every frame, and runaway frames are truncated.
module eth_tx_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_LEN    = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s0_data,
  input  logic        s0_valid,
  input  logic        s0_last,
  output logic        s0_ready,
  input  logic [7:0]  s1_data,
  input  logic        s1_valid,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_err,
  input  logic        m_ready,
  output logic [1:0]  grant,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_trunc
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, GAP} state_e;

  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
  localparam logic [15:0] GAP_C     = 16'(GAP_CYCLES);
  // With a zero gap the frame end returns straight to the grant decision.
  localparam state_e      DONE_ST   = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_owner_q, last_owner_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] frames_ok_q, frames_ok_d;
  logic [15:0] frames_trunc_q, frames_trunc_d;

  logic        owner_s;
  logic [7:0]  own_data_s;
  logic        own_valid_s;
  logic        own_last_s;
  logic        own_ready_s;
  logic        new_owner_s;
  logic        at_max_s;

  assign owner_s     = grant_q[1];
  assign own_data_s  = owner_s ? s1_data  : s0_data;
  assign own_valid_s = owner_s ? s1_valid : s0_valid;
  assign own_last_s  = owner_s ? s1_last  : s0_last;
  assign at_max_s    = ((byte_cnt_q + 11'd1) == MAX_LEN_C);

  assign s0_ready     = own_ready_s & ~owner_s;
  assign s1_ready     = own_ready_s & owner_s;
  assign grant        = grant_q;
  assign frames_ok    = frames_ok_q;
  assign frames_trunc = frames_trunc_q;

  // Next-state, counter updates and the combinational owner datapath.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_owner_d   = last_owner_q;
    byte_cnt_d     = byte_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    frames_ok_d    = frames_ok_q;
    frames_trunc_d = frames_trunc_q;
    new_owner_s    = 1'b0;
    own_ready_s    = 1'b0;
    m_data         = 8'd0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    m_err          = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) begin
          new_owner_s = ~last_owner_q;
        end else if (s1_valid) begin
          new_owner_s = 1'b1;
        end else begin
          new_owner_s = 1'b0;
        end
        if (s0_valid || s1_valid) begin
          grant_d      = new_owner_s ? 2'b10 : 2'b01;
          last_owner_d = new_owner_s;
          byte_cnt_d   = 11'd0;
          state_d      = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        m_data      = own_data_s;
        m_valid     = own_valid_s;
        m_last      = own_valid_s & (own_last_s | at_max_s);
        m_err       = own_valid_s & ~own_last_s & at_max_s;
        own_ready_s = m_ready;
        if (own_valid_s && m_ready) begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          if (own_last_s) begin
            frames_ok_d = frames_ok_q + 16'd1;
            grant_d     = 2'b00;
            gap_cnt_d   = GAP_C;
            state_d     = DONE_ST;
          end else if (at_max_s) begin
            frames_trunc_d = frames_trunc_q + 16'd1;
            state_d        = DRAIN;
          end else begin
            state_d = GRANT;
          end
        end else begin
          state_d = GRANT;
        end
      end
      DRAIN: begin
        // Remainder of a truncated frame is swallowed without involving the MAC.
        own_ready_s = 1'b1;
        if (own_valid_s && own_last_s) begin
          grant_d   = 2'b00;
          gap_cnt_d = GAP_C;
          state_d   = DONE_ST;
        end else begin
          state_d = DRAIN;
        end
      end
      GAP: begin
        if (gap_cnt_q <= 16'd1) begin
          gap_cnt_d = 16'd0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State and counter registers; last_owner resets to 1 so s0 wins first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_q        <= 2'b00;
      last_owner_q   <= 1'b1;
      byte_cnt_q     <= 11'd0;
      gap_cnt_q      <= 16'd0;
      frames_ok_q    <= 16'd0;
      frames_trunc_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_owner_q   <= last_owner_d;
      byte_cnt_q     <= byte_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      frames_ok_q    <= frames_ok_d;
      frames_trunc_q <= frames_trunc_d;
    end
  end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Frame-level round-robin arbiter that shares the single MAC transmit byte stream between two frame sources, for example an ARP responder and a UDP sender. It sits directly upstream of the RMII transmit MAC. The MAC adds preamble/SFD, pads to 64 bytes and appends FCS.
- Grants whole frames only.
- Enforces a programmable idle gap between granted frames.
- Truncates runaway frames at a maximum length.
- Keeps per-outcome frame counters.

## Interface
Parameters:
- GAP_CYCLES, 4: idle clk cycles inserted after every frame before the next grant decision. 0 is legal.
- MAX_LEN, 1514: maximum bytes forwarded per frame, excluding FCS. Range 1..2047.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- s0_data  in  8  requester 0 frame byte.
- s0_valid  in  1  requester 0 byte valid.
- s0_last  in  1  requester 0 final byte of frame.
- s0_ready  out  1  requester 0 byte accepted when valid&ready.
- s1_data / s1_valid / s1_last / s1_ready  same as s0, for requester 1.
- m_data  out  8  byte to MAC.
- m_valid  out  1  byte valid to MAC.
- m_last  out  1  final byte of frame.
- m_err  out  1  qualifies m_last: frame was truncated, MAC must corrupt FCS/abort.
- m_ready  in  1  MAC accepts byte.
- grant  out  2  one-hot current owner; 2'b00 when no frame is granted.
- frames_ok  out  16  count of frames forwarded complete; wraps.
- frames_trunc  out  16  count of truncated frames; wraps.

## Operation
- State machine: IDLE, GRANT, DRAIN, GAP.
- Registers: state, grant, last_owner (1 bit), byte_cnt (11 bit), gap_cnt, both frame counters.
- IDLE:
  - If exactly one s*_valid is high, next grant goes to that requester.
  - If both are high, next grant goes to the requester != last_owner.
  - On a grant: last_owner <= new owner, byte_cnt <= 0, move to GRANT.
  - If neither is valid, stay in IDLE.
- GRANT datapath is combinational pass-through from the owner:
  - m_data = owner data.
  - m_valid = owner valid.
  - m_last = owner last, OR forced as below.
  - owner ready = m_ready.
  - Non-owner ready = 0.
- GRANT beat handling. A beat is accepted when m_valid&m_ready; byte_cnt increments on each accepted beat.
  - Accepted beat with owner last = 1 and byte_cnt+1 <= MAX_LEN: frames_ok++, go to GAP.
  - Accepted beat with byte_cnt+1 == MAX_LEN and owner last = 0:
    - m_last = 1 and m_err = 1 on that beat.
    - frames_trunc++.
    - Go to DRAIN.
- DRAIN:
  - m_valid = 0.
  - Owner ready = 1. Owner bytes are discarded regardless of m_ready.
  - Owner beat with last = 1: go to GAP.
- GAP:
  - grant = 0, all s*_ready = 0, m_valid = 0.
  - gap_cnt loads GAP_CYCLES on entry and decrements each cycle.
  - Return to IDLE when gap_cnt reaches 0. If GAP_CYCLES = 0, GAP lasts zero cycles: the exit from GRANT/DRAIN goes straight to IDLE.
- m_err = 0 except on the truncation beat. m_last and m_err are 0 whenever m_valid = 0.
- Owner deasserting valid mid-frame is a legal stall. Grant is held, with no timeout.
- Reset values:
  - state IDLE, grant 0, last_owner 1 (s0 wins the first contention).
  - byte_cnt 0, gap_cnt 0, frames_ok 0, frames_trunc 0.
  - All outputs 0.
- Reset mid-frame aborts immediately: m_valid drops the next cycle. The partial frame is not counted.

## Timing
- Grant decision is registered. s*_valid rising in IDLE at cycle T gives grant/GRANT at T+1, so the first byte can be accepted at T+1.
- Data path latency 0: m_* follow s* combinationally while in GRANT. s*_ready follows m_ready combinationally.
- Last beat accepted at T:
  - GAP occupies T+1..T+GAP_CYCLES.
  - IDLE at T+GAP_CYCLES+1.
  - Next grant earliest at T+GAP_CYCLES+2.
- The frame counter update is visible the cycle after the accepting beat.
- A requester raising valid during GAP or during another owner's frame waits. Its data must be held; no byte is lost.

## Test plan
- Single frame: s0 sends 60 bytes with m_ready=1 and GAP_CYCLES=4.
  - grant=01 one cycle after s0_valid.
  - 60 bytes pass unchanged; m_last on byte 60 with m_err=0.
  - frames_ok=1, grant=00 for 4 cycles.
- Contention: s0 and s1 both valid from reset, each with 3 queued 64-byte frames.
  - Grant order: s0, s1, s0, s1, s0, s1.
  - Never two grants without an intervening GAP.
  - frames_ok=6.
- Backpressure: m_ready toggles 1/0 every cycle during a 100-byte s1 frame.
  - s1_ready mirrors m_ready.
  - Exactly 100 accepted beats in order; no duplication.
- Truncation: MAX_LEN=64, s0 sends 80 bytes.
  - 64 bytes forwarded; byte 64 has m_last=1 and m_err=1.
  - Bytes 65..80 are consumed with m_valid=0.
  - frames_trunc=1, frames_ok=0.
- Edges:
  - A frame of exactly MAX_LEN bytes ending with last gives m_err=0 and counts in frames_ok.
  - GAP_CYCLES=0 gives the next grant 2 cycles after the last beat.
- Reset mid-frame: assert rst at byte 30 of a 60-byte s0 frame.
  - Next cycle: grant=0, m_valid=0, counters=0.
  - After release with both valid, s0 is granted first.
